// File: rtl/game_gen2.sv
// game_gen2: two-sided count-to-target game built on one shared wrap-around counter.
// Latency: outputs are registered; WINNER/LOSER decode count and state combinationally.
// Flow control: none; enable gates stepping in RUN, and INIT restarts a game from any state.
// Optional feature macro: GAME_AUTORELOAD_EN (a win or loss event reloads count from a shadow copy).
module game_gen2 #(
  parameter int WIDTH  = 4,
  parameter int TARGET = 15,
  parameter int TW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INIT,
  input  logic [WIDTH-1:0] initialValue,
  input  logic [1:0]       controlValue,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             WINNER,
  output logic             LOSER,
  output logic [TW-1:0]    win_tally,
  output logic [TW-1:0]    lose_tally,
  output logic             GAMEOVER,
  output logic [1:0]       WHO
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [TW-1:0]    TGT     = TW'(TARGET);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_count;
  logic [TW-1:0]    win_next;
  logic [TW-1:0]    lose_next;
  logic             win_evt;
  logic             lose_evt;

  // Boundary flags only mean something while a game is actually running.
  assign WINNER = (state == S_RUN) && (count == MAX_VAL);
  assign LOSER  = (state == S_RUN) && (count == '0);

  // An event is counted only on an enabled edge that is not being overridden by INIT.
  assign win_evt  = WINNER && enable && !INIT;
  assign lose_evt = LOSER  && enable && !INIT;

  assign win_next  = win_tally  + TW'(1);
  assign lose_next = lose_tally + TW'(1);

  // Wrapping step for the selected mode; width truncation gives the modulo.
  always_comb begin
    step_val = count;
    case (controlValue)
      2'b00:   step_val = count + WIDTH'(1);
      2'b01:   step_val = count + WIDTH'(2);
      2'b10:   step_val = count - WIDTH'(1);
      default: step_val = count - WIDTH'(2);
    endcase
  end

`ifdef GAME_AUTORELOAD_EN
  logic [WIDTH-1:0] shadow;

  // Shadow copy of the load value, reused as the reload point after every event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (INIT) begin
      shadow <= initialValue;
    end
  end

  // Events reload instead of stepping, so a boundary load value repeats its event.
  always_comb begin
    next_count = step_val;
    if (win_evt || lose_evt) begin
      next_count = shadow;
    end
  end
`else
  // Without autoreload the counter always steps and wraps.
  always_comb begin
    next_count = step_val;
  end
`endif

  // Game state machine: counter, tallies, and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      win_tally  <= '0;
      lose_tally <= '0;
      GAMEOVER   <= 1'b0;
      WHO        <= 2'b00;
    end else if (INIT) begin
      // Load and (re)start; no step and no tally change on this edge.
      state      <= S_RUN;
      count      <= initialValue;
      win_tally  <= '0;
      lose_tally <= '0;
      GAMEOVER   <= 1'b0;
      WHO        <= 2'b00;
    end else begin
      case (state)
        S_RUN: begin
          if (enable) begin
            // The final step still applies on the game-ending edge.
            count <= next_count;
            if (win_evt) begin
              win_tally <= win_next;
              if (win_next == TGT) begin
                state    <= S_OVER;
                GAMEOVER <= 1'b1;
                WHO      <= 2'b10;
              end
            end else if (lose_evt) begin
              lose_tally <= lose_next;
              if (lose_next == TGT) begin
                state    <= S_OVER;
                GAMEOVER <= 1'b1;
                WHO      <= 2'b01;
              end
            end
          end
        end
        S_OVER: begin
          // Frozen until INIT or reset.
          GAMEOVER <= 1'b1;
        end
        default: begin
          // IDLE: wait for INIT, enable is ignored.
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
